// File: rtl/range_scan_seq.sv
// Search-range reader: walks an ordered address window, reads each word, compares it to a key.
// Optional macro SCAN_COUNT_EN: scan the whole window and count hits on match_cnt.
module range_scan_seq #(
    parameter int ADR_W  = 5,
    parameter int DATA_W = 8,
    parameter int RD_LAT = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ADR_W-1:0]  start_adr,
    input  logic [ADR_W-1:0]  end_adr,
    input  logic              same,
    input  logic [DATA_W-1:0] key,
    input  logic              abort,
    output logic              mem_rd,
    output logic [ADR_W-1:0]  mem_adr,
    input  logic [DATA_W-1:0] mem_data,
    output logic              busy,
    output logic              done,
    output logic              found,
    output logic [ADR_W-1:0]  match_adr
`ifdef SCAN_COUNT_EN
    ,
    output logic [ADR_W:0]    match_cnt
`endif
);

    typedef enum logic [2:0] {S_IDLE, S_READ, S_WAIT, S_CMP, S_DONE} state_t;

    localparam logic [2:0] WAIT_INIT = (RD_LAT > 1) ? 3'(RD_LAT - 2) : 3'd0;
`ifdef SCAN_COUNT_EN
    localparam logic STOP_ON_HIT = 1'b0;
`else
    localparam logic STOP_ON_HIT = 1'b1;
`endif

    state_t             r_state;
    logic [ADR_W:0]     r_cur;
    logic [ADR_W-1:0]   r_hi;
    logic [DATA_W-1:0]  r_key;
    logic [2:0]         r_wait;
    logic               r_mem_rd;
    logic [ADR_W-1:0]   r_mem_adr;
    logic               r_busy;
    logic               r_done;
    logic               r_found;
    logic [ADR_W-1:0]   r_match_adr;
`ifdef SCAN_COUNT_EN
    logic [ADR_W:0]     r_match_cnt;
`endif

    logic               w_hit;
    logic               w_last;
    logic [ADR_W-1:0]   w_lo;
    logic [ADR_W-1:0]   w_hi;
    logic [ADR_W:0]     w_nxt;

    // Window is re-ordered here; upstream ordering is not trusted.
    assign w_lo   = same ? start_adr : ((start_adr <= end_adr) ? start_adr : end_adr);
    assign w_hi   = same ? start_adr : ((start_adr <= end_adr) ? end_adr : start_adr);
    assign w_hit  = (mem_data == r_key);
    // End test before increment; cur is one bit wider so the top address never wraps.
    assign w_last = (r_cur == {1'b0, r_hi});
    assign w_nxt  = r_cur + 1'b1;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_cur       <= '0;
            r_hi        <= '0;
            r_key       <= '0;
            r_wait      <= '0;
            r_mem_rd    <= 1'b0;
            r_mem_adr   <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_found     <= 1'b0;
            r_match_adr <= '0;
`ifdef SCAN_COUNT_EN
            r_match_cnt <= '0;
`endif
        end else begin
            r_mem_rd <= 1'b0;
            r_done   <= 1'b0;
            if (abort && r_state != S_IDLE) begin
                r_state     <= S_IDLE;
                r_busy      <= 1'b0;
                r_found     <= 1'b0;
                r_match_adr <= '0;
`ifdef SCAN_COUNT_EN
                r_match_cnt <= '0;
`endif
            end else begin
                case (r_state)
                    S_IDLE: begin
                        if (start && !abort) begin
                            r_key       <= key;
                            r_cur       <= {1'b0, w_lo};
                            r_hi        <= w_hi;
                            r_found     <= 1'b0;
                            r_match_adr <= '0;
`ifdef SCAN_COUNT_EN
                            r_match_cnt <= '0;
`endif
                            r_busy      <= 1'b1;
                            r_mem_rd    <= 1'b1;
                            r_mem_adr   <= w_lo;
                            r_state     <= S_READ;
                        end
                    end
                    S_READ: begin
                        if (RD_LAT > 1) begin
                            r_wait  <= WAIT_INIT;
                            r_state <= S_WAIT;
                        end else begin
                            r_state <= S_CMP;
                        end
                    end
                    S_WAIT: begin
                        if (r_wait == 3'd0) r_state <= S_CMP;
                        else                r_wait  <= r_wait - 3'd1;
                    end
                    S_CMP: begin
                        if (w_hit && !r_found) begin
                            r_found     <= 1'b1;
                            r_match_adr <= r_cur[ADR_W-1:0];
                        end
`ifdef SCAN_COUNT_EN
                        if (w_hit) r_match_cnt <= r_match_cnt + 1'b1;
`endif
                        if ((w_hit && STOP_ON_HIT) || w_last) begin
                            r_done  <= 1'b1;
                            r_state <= S_DONE;
                        end else begin
                            // Strobe for the next address is issued on the way into READ.
                            r_cur     <= w_nxt;
                            r_mem_rd  <= 1'b1;
                            r_mem_adr <= w_nxt[ADR_W-1:0];
                            r_state   <= S_READ;
                        end
                    end
                    S_DONE: begin
                        r_busy  <= 1'b0;
                        r_state <= S_IDLE;
                    end
                    default: r_state <= S_IDLE;
                endcase
            end
        end
    end

    assign mem_rd    = r_mem_rd;
    assign mem_adr   = r_mem_adr;
    assign busy      = r_busy;
    assign done      = r_done;
    assign found     = r_found;
    assign match_adr = r_match_adr;
`ifdef SCAN_COUNT_EN
    assign match_cnt = r_match_cnt;
`endif

endmodule

// File: tb/tb_range_scan_seq.sv
// Scoreboard bench for range_scan_seq: one instance at RD_LAT=1, one at RD_LAT=3, shared memory model.
module tb_range_scan_seq;

`ifdef SCAN_COUNT_EN
    localparam bit CNT = 1'b1;
`else
    localparam bit CNT = 1'b0;
`endif

    typedef struct {int d; int adr; int cyc;} rd_t;
    typedef struct {int d; int f; int ma; int cnt; int cyc;} res_t;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       start_v [2];
    logic [4:0] start_adr, end_adr;
    logic       same, abort;
    logic [7:0] key;
    logic       rd_v [2];
    logic [4:0] adr_v [2];
    logic [7:0] mdata_v [2];
    logic       busy_v [2];
    logic       done_v [2];
    logic       found_v [2];
    logic [4:0] madr_v [2];
`ifdef SCAN_COUNT_EN
    logic [5:0] cnt_v [2];
`endif

    logic [7:0] mem [32];
    logic [5:0] pa [2][7];
    int cyc = 0;
    int n_chk = 0;
    int n_fail = 0;
    rd_t  rdq[$];
    res_t resq[$];
    rd_t  me;
    res_t mr;
    bit   bchk [2];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    range_scan_seq #(.ADR_W(5), .DATA_W(8), .RD_LAT(1)) u_dut1 (
        .clk(clk), .reset(reset), .start(start_v[0]), .start_adr(start_adr), .end_adr(end_adr),
        .same(same), .key(key), .abort(abort), .mem_rd(rd_v[0]), .mem_adr(adr_v[0]),
        .mem_data(mdata_v[0]), .busy(busy_v[0]), .done(done_v[0]), .found(found_v[0]),
        .match_adr(madr_v[0])
`ifdef SCAN_COUNT_EN
        , .match_cnt(cnt_v[0])
`endif
    );

    range_scan_seq #(.ADR_W(5), .DATA_W(8), .RD_LAT(3)) u_dut3 (
        .clk(clk), .reset(reset), .start(start_v[1]), .start_adr(start_adr), .end_adr(end_adr),
        .same(same), .key(key), .abort(abort), .mem_rd(rd_v[1]), .mem_adr(adr_v[1]),
        .mem_data(mdata_v[1]), .busy(busy_v[1]), .done(done_v[1]), .found(found_v[1]),
        .match_adr(madr_v[1])
`ifdef SCAN_COUNT_EN
        , .match_cnt(cnt_v[1])
`endif
    );

    // Read pipeline: data for a strobe appears RD_LAT edges later; zero when nothing is in flight.
    always @(posedge clk) begin
        for (int d = 0; d < 2; d++) begin
            for (int j = 6; j > 0; j--) pa[d][j] <= pa[d][j-1];
            pa[d][0] <= {rd_v[d], adr_v[d]};
        end
    end
    assign mdata_v[0] = pa[0][0][5] ? mem[pa[0][0][4:0]] : 8'h00;
    assign mdata_v[1] = pa[1][2][5] ? mem[pa[1][2][4:0]] : 8'h00;

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: every strobe and every done pulse must match the head of its queue.
    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) begin
            if (bchk[d]) begin
                chk("busy_after_done", int'(busy_v[d]), 0);
                bchk[d] = 1'b0;
            end
            if (rd_v[d]) begin
                chk("rd_pending", (rdq.size() > 0) ? 1 : 0, 1);
                if (rdq.size() > 0) begin
                    me = rdq.pop_front();
                    chk("rd_dut", d, me.d);
                    chk("rd_adr", int'(adr_v[d]), me.adr);
                    chk("rd_cycle", cyc, me.cyc);
                end
            end
            if (done_v[d]) begin
                chk("done_pending", (resq.size() > 0) ? 1 : 0, 1);
                if (resq.size() > 0) begin
                    mr = resq.pop_front();
                    chk("done_dut", d, mr.d);
                    chk("done_cycle", cyc, mr.cyc);
                    chk("found", int'(found_v[d]), mr.f);
                    chk("match_adr", int'(madr_v[d]), mr.ma);
`ifdef SCAN_COUNT_EN
                    chk("match_cnt", int'(cnt_v[d]), mr.cnt);
`endif
                    chk("busy_at_done", int'(busy_v[d]), 1);
                    bchk[d] = 1'b1;
                end
            end
        end
    end

    task automatic clrmem();
        for (int i = 0; i < 32; i++) mem[i] = 8'h00;
    endtask

    // Issue one scan; expected reads are lo..lo+n-1 at RD_LAT+1 spacing, done at n*(RD_LAT+1)+1.
    task automatic scan(input int d, input logic [4:0] sa, input logic [4:0] ea, input logic sm,
                        input logic [7:0] k, input int lo, input int n, input int ef,
                        input int ema, input int ecnt, input int poke);
        int s, t, lat;
        lat = (d == 0) ? 1 : 3;
        @(negedge clk);
        s = cyc;
        for (int i = 0; i < n; i++) rdq.push_back('{d, lo + i, s + 1 + i * (lat + 1)});
        resq.push_back('{d, ef, ema, ecnt, s + 1 + n * (lat + 1)});
        start_adr = sa; end_adr = ea; same = sm; key = k; start_v[d] = 1'b1;
        @(negedge clk);
        start_v[d] = 1'b0;
        if (poke >= 0) begin
            while (cyc < s + 1 + poke) @(negedge clk);
            start_adr = 5'd0; end_adr = 5'd0; same = 1'b1; key = 8'h00; start_v[d] = 1'b1;
            @(negedge clk);
            start_v[d] = 1'b0;
        end
        t = 0;
        while (resq.size() != 0 && t < 300) begin
            @(negedge clk);
            t++;
        end
        chk("done_seen", resq.size(), 0);
        if (resq.size() != 0) begin
            rdq.delete();
            resq.delete();
        end
        repeat (2) @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int s;
        start_v[0] = 1'b0; start_v[1] = 1'b0;
        start_adr = '0; end_adr = '0; same = 1'b0; key = '0; abort = 1'b0;
        bchk[0] = 1'b0; bchk[1] = 1'b0;
        for (int d = 0; d < 2; d++) for (int j = 0; j < 7; j++) pa[d][j] = '0;
        clrmem();
        #3;
        chk("rst_mem_rd", int'(rd_v[0]), 0);
        chk("rst_busy", int'(busy_v[0]), 0);
        chk("rst_done", int'(done_v[1]), 0);
        chk("rst_found", int'(found_v[0]), 0);
        chk("rst_match_adr", int'(madr_v[1]), 0);
        chk("rst_mem_adr", int'(adr_v[0]), 0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        repeat (2) @(negedge clk);

        // Hit at 5 in window 3..7.
        mem[5] = 8'hA5;
        scan(0, 5'd3, 5'd7, 1'b0, 8'hA5, 3, CNT ? 5 : 3, 1, 5, 1, -1);
        // Reversed window, no hit; a start mid-scan must be ignored.
        clrmem();
        scan(0, 5'd9, 5'd2, 1'b0, 8'h3C, 2, 8, 0, 0, 0, 3);
        // Single address at the top; a copy at 0 would expose a wrap.
        mem[31] = 8'h77; mem[0] = 8'h77;
        scan(0, 5'd31, 5'd31, 1'b1, 8'h77, 31, 1, 1, 31, 1, -1);
        clrmem();
        mem[0] = 8'h99;
        scan(0, 5'd28, 5'd31, 1'b0, 8'h99, 28, 4, 0, 0, 0, -1);
        // RD_LAT=3 instance, hit at 1.
        clrmem();
        mem[1] = 8'h42;
        scan(1, 5'd0, 5'd1, 1'b0, 8'h42, 0, 2, 1, 1, 1, -1);
        // Multiple hits: first hit reported, count covers the full window.
        clrmem();
        mem[2] = 8'hE1; mem[8] = 8'hE1; mem[15] = 8'hE1;
        scan(0, 5'd0, 5'd15, 1'b0, 8'hE1, 0, CNT ? 16 : 3, 1, 2, CNT ? 3 : 1, -1);

        // Abort during the read of address 5.
        clrmem();
        mem[5] = 8'hA5;
        @(negedge clk);
        s = cyc;
        rdq.push_back('{0, 3, s + 1});
        rdq.push_back('{0, 4, s + 3});
        rdq.push_back('{0, 5, s + 5});
        start_adr = 5'd3; end_adr = 5'd7; same = 1'b0; key = 8'hA5; start_v[0] = 1'b1;
        @(negedge clk);
        start_v[0] = 1'b0;
        while (cyc < s + 5) @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk("abort_busy", int'(busy_v[0]), 0);
        chk("abort_found", int'(found_v[0]), 0);
        chk("abort_match_adr", int'(madr_v[0]), 0);
        chk("abort_mem_rd", int'(rd_v[0]), 0);
        // start with abort in IDLE is dropped.
        start_v[0] = 1'b1; abort = 1'b1;
        @(negedge clk);
        start_v[0] = 1'b0; abort = 1'b0;
        repeat (4) @(negedge clk);
        chk("abort_start_busy", int'(busy_v[0]), 0);
        chk("abort_rdq_empty", rdq.size(), 0);

        // Reset mid-scan, after the first hit has registered.
        clrmem();
        mem[5] = 8'hC3;
        @(negedge clk);
        s = cyc;
        rdq.push_back('{0, 5, s + 1});
        if (CNT) rdq.push_back('{0, 6, s + 3});
        else     resq.push_back('{0, 1, 5, 1, s + 3});
        start_adr = 5'd5; end_adr = 5'd9; same = 1'b0; key = 8'hC3; start_v[0] = 1'b1;
        @(negedge clk);
        start_v[0] = 1'b0;
        while (cyc < s + 3) @(negedge clk);
        chk("pre_rst_found", int'(found_v[0]), 1);
        chk("pre_rst_busy", int'(busy_v[0]), 1);
        #2 reset = 1'b1;
        #1;
        chk("arst_mem_rd", int'(rd_v[0]), 0);
        chk("arst_mem_adr", int'(adr_v[0]), 0);
        chk("arst_busy", int'(busy_v[0]), 0);
        chk("arst_done", int'(done_v[0]), 0);
        chk("arst_found", int'(found_v[0]), 0);
        chk("arst_match_adr", int'(madr_v[0]), 0);
`ifdef SCAN_COUNT_EN
        chk("arst_match_cnt", int'(cnt_v[0]), 0);
`endif
        repeat (2) @(negedge clk);
        reset = 1'b0;
        repeat (6) @(negedge clk);
        chk("end_rdq_empty", rdq.size(), 0);
        chk("end_resq_empty", resq.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
